sha256_w_schedule: RTL and testbench

SHA-256 message-schedule generator that sits directly downstream of the `wEn` enable stage. While `enable` is high it emits one schedule word W_t per cycle, t = 0..63. W_0..W_15 come from the current 512-bit block buffer; W_16..W_63 are expanded internally. Results go to the compression-round stage.

---
 rtl/sha256_pkg.sv | 34 +++
 rtl/sha256_w_expand.sv | 13 +
 rtl/sha256_w_schedule.sv | 66 ++++++
 tb/tb_sha256_w_schedule.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 types, constants and sigma functions
package sha256_pkg;
  localparam int SHA_WORD_W = 32;
  localparam int SHA_NUM_W = 64;
  typedef logic [SHA_WORD_W-1:0] sha_word_t;
  typedef enum logic {RUN, WAIT_LOW} ws_state_e;
  localparam sha_word_t SHA_K [SHA_NUM_W] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  function automatic sha_word_t rotr(input sha_word_t x, input int n);
    logic [2*SHA_WORD_W-1:0] d;
    d = {x, x} >> n;
    return d[SHA_WORD_W-1:0];
  endfunction
  function automatic sha_word_t ssig0(input sha_word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic sha_word_t ssig1(input sha_word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic sha_word_t bsig0(input sha_word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic sha_word_t bsig1(input sha_word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
endpackage

// File: rtl/sha256_w_expand.sv
// sha256_w_expand: combinational W_t expansion from four earlier schedule words
module sha256_w_expand
  import sha256_pkg::*;
(
  input  sha_word_t w2,
  input  sha_word_t w7,
  input  sha_word_t w15,
  input  sha_word_t w16,
  output sha_word_t w_new
);
  // two-level adder keeps sigma1 plus three adds shallow
  assign w_new = (ssig1(w2) + w7) + (ssig0(w15) + w16);
endmodule

// File: rtl/sha256_w_schedule.sv
// sha256_w_schedule: emits W_0..W_63 one per enabled cycle, then waits for enable to drop
module sha256_w_schedule
  import sha256_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int NUM_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  output logic [3:0]        m_addr,
  input  logic [WORD_W-1:0] m_word,
  output logic [WORD_W-1:0] w_out,
  output logic [5:0]        w_index,
  output logic              w_valid,
  output logic              done
);
  ws_state_e state, state_nxt;
  logic [5:0] t;
  sha_word_t win [16];
  sha_word_t w_exp, w_new;
  logic fire, last;
  assign m_addr = t[3:0];
  assign fire = state == RUN && enable;
  assign last = t == 6'(NUM_W - 1);
  assign w_new = t < 6'd16 ? m_word : w_exp;
  sha256_w_expand u_expand (
    .w2(win[14]),
    .w7(win[9]),
    .w15(win[1]),
    .w16(win[0]),
    .w_new(w_exp)
  );
  // leave RUN after the last word; hold in WAIT_LOW until enable drops
  always_comb begin
    state_nxt = state == RUN ? (fire && last ? WAIT_LOW : RUN) : (enable ? WAIT_LOW : RUN);
  end
  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= RUN;
    else state <= state_nxt;
  end
  // counter, shift window and registered output beat
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      t <= '0;
      win <= '{default: '0};
      w_out <= '0;
      w_index <= '0;
      w_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      w_valid <= fire;
      done <= fire && last;
      if (fire) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= w_new;
        w_out <= w_new;
        w_index <= t;
        t <= t + 6'd1;
      end else if (state == WAIT_LOW && !enable) begin
        t <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sha256_w_schedule.sv
// tb_sha256_w_schedule: directed and randomized checks of the SHA-256 message schedule
module tb_sha256_w_schedule;
  logic clock = 1'b0, reset = 1'b0, enable = 1'b0;
  logic [3:0] m_addr;
  logic [31:0] m_word, w_out;
  logic [5:0] w_index;
  logic w_valid, done;
  logic [31:0] msg [16];
  int n_checks = 0, n_fail = 0, cyc = 0, stray_done = 0;
  logic [31:0] cap_w[$];
  int cap_i[$], cap_c[$], done_i[$], done_c[$];

  typedef struct {
    string name;
    int blk;
    int idx;
    logic [31:0] exp;
  } vec_t;

  always #5 clock = ~clock;
  assign m_word = msg[m_addr];

  sha256_w_schedule dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .m_addr(m_addr),
    .m_word(m_word),
    .w_out(w_out),
    .w_index(w_index),
    .w_valid(w_valid),
    .done(done)
  );

  always @(posedge clock) begin
    #1;
    cyc++;
    if (w_valid) begin
      cap_w.push_back(w_out);
      cap_i.push_back(int'(w_index));
      cap_c.push_back(cyc);
      if (done) begin
        done_i.push_back(int'(w_index));
        done_c.push_back(cyc);
      end
    end else if (done) stray_done++;
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic model(input logic [31:0] m[16], output logic [31:0] w[64]);
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = m[i];
      else w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                  + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic clear_caps();
    cap_w.delete();
    cap_i.delete();
    cap_c.delete();
    done_i.delete();
    done_c.delete();
    stray_done = 0;
  endtask

  task automatic drive_block(input int sl[64]);
    for (int k = 0; k < 64; k++) begin
      repeat (sl[k]) begin
        enable = 1'b0;
        @(negedge clock);
      end
      enable = 1'b1;
      @(negedge clock);
    end
  endtask

  task automatic check_pass(input string tag, input logic [31:0] exp[64], input int span);
    chk($sformatf("%s beats", tag), cap_w.size(), 64);
    for (int i = 0; i < cap_w.size() && i < 64; i++) begin
      chk($sformatf("%s idx[%0d]", tag, i), cap_i[i], i);
      chk($sformatf("%s w[%0d]", tag, i), cap_w[i], exp[i]);
    end
    chk($sformatf("%s done_count", tag), done_i.size(), 1);
    chk($sformatf("%s stray_done", tag), stray_done, 0);
    if (done_i.size() > 0) chk($sformatf("%s done_index", tag), done_i[0], 63);
    if (done_c.size() > 0 && cap_c.size() > 0)
      chk($sformatf("%s done_span", tag), done_c[0] - cap_c[0], span);
  endtask

  initial begin
    int sl[64];
    int rel, span;
    logic [31:0] exp[64];
    vec_t vecs[11];
    vecs[0] = '{"abc W0", 0, 0, 32'h61626380};
    vecs[1] = '{"abc W1", 0, 1, 32'h00000000};
    vecs[2] = '{"abc W14", 0, 14, 32'h00000000};
    vecs[3] = '{"abc W15", 0, 15, 32'h00000018};
    vecs[4] = '{"abc W16", 0, 16, 32'h61626380};
    vecs[5] = '{"abc W17", 0, 17, 32'h000F0000};
    vecs[6] = '{"abc W18", 0, 18, 32'h7DA86405};
    vecs[7] = '{"abc W63", 0, 63, 32'h12B1EDEB};
    vecs[8] = '{"ones W0", 1, 0, 32'hFFFFFFFF};
    vecs[9] = '{"ones W15", 1, 15, 32'hFFFFFFFF};
    vecs[10] = '{"ones W16", 1, 16, 32'h203FFFFC};
    foreach (msg[i]) msg[i] = '0;
    msg[0] = 32'h61626380;
    msg[15] = 32'h00000018;
    repeat (2) @(negedge clock);
    chk("rst w_out", w_out, 0);
    chk("rst w_index", w_index, 0);
    chk("rst w_valid", w_valid, 0);
    chk("rst done", done, 0);
    chk("rst m_addr", m_addr, 0);
    // abc block, enable already high at reset release
    enable = 1'b1;
    reset = 1'b1;
    rel = cyc;
    clear_caps();
    foreach (sl[i]) sl[i] = 0;
    drive_block(sl);
    if (cap_c.size() > 0) chk("first beat after release", cap_c[0], rel + 1);
    model(msg, exp);
    check_pass("abc", exp, 63);
    foreach (vecs[i]) if (vecs[i].blk == 0 && cap_w.size() > vecs[i].idx) chk(vecs[i].name, cap_w[vecs[i].idx], vecs[i].exp);
    // same block with stalls at t=5 (3 cycles) and t=40 (5 cycles)
    enable = 1'b0;
    @(negedge clock);
    clear_caps();
    sl[5] = 3;
    sl[40] = 5;
    drive_block(sl);
    check_pass("stall", exp, 71);
    // enable held high after done: no second pass
    clear_caps();
    repeat (20) @(negedge clock);
    chk("hold beats", cap_w.size(), 0);
    chk("hold done", stray_done + done_i.size(), 0);
    enable = 1'b0;
    @(negedge clock);
    clear_caps();
    foreach (sl[i]) sl[i] = 0;
    drive_block(sl);
    check_pass("rerun", exp, 63);
    // asynchronous reset mid-block
    enable = 1'b0;
    @(negedge clock);
    clear_caps();
    enable = 1'b1;
    repeat (30) @(negedge clock);
    chk("pre-rst beats", cap_w.size(), 30);
    chk("pre-rst m_addr", m_addr, 14);
    chk("pre-rst w_valid", w_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("async w_out", w_out, 0);
    chk("async w_index", w_index, 0);
    chk("async w_valid", w_valid, 0);
    chk("async done", done, 0);
    chk("async m_addr", m_addr, 0);
    @(negedge clock);
    reset = 1'b1;
    clear_caps();
    drive_block(sl);
    check_pass("post_rst", exp, 63);
    // modulo wrap: all-ones block
    foreach (msg[i]) msg[i] = 32'hFFFFFFFF;
    enable = 1'b0;
    @(negedge clock);
    clear_caps();
    drive_block(sl);
    model(msg, exp);
    check_pass("ones", exp, 63);
    foreach (vecs[i]) if (vecs[i].blk == 1 && cap_w.size() > vecs[i].idx) chk(vecs[i].name, cap_w[vecs[i].idx], vecs[i].exp);
    // random blocks with random stalls
    for (int b = 0; b < 250; b++) begin
      foreach (msg[i]) msg[i] = $urandom;
      span = 63;
      foreach (sl[i]) begin
        sl[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
        if (i > 0) span += sl[i];
      end
      enable = 1'b0;
      @(negedge clock);
      clear_caps();
      drive_block(sl);
      model(msg, exp);
      check_pass($sformatf("rnd%0d", b), exp, span);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
